// File: rtl/bound_flasher_pkg.sv
// Shared types for the bound flasher: the 3-bit state encoding and the
// elaboration-time parameter legality check.
package bound_flasher_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1_UP = 3'd1,
        S2_DN = 3'd2,
        S3_UP = 3'd3,
        S4_DN = 3'd4,
        S5_UP = 3'd5,
        S6_DN = 3'd6,
        KB_DN = 3'd7
    } state_t;

    function automatic bit params_ok(input int width, input int b_lo,
                                     input int b_hi, input int div);
        return (width >= 4) && (width <= 64) && (b_lo >= 1) &&
               (b_lo < b_hi) && (b_hi < width) && (div >= 1);
    endfunction

endpackage

// File: rtl/flasher_tick_gen.sv
// Step prescaler: pulses tick once every DIV cycles while run is high and
// parks its count at zero otherwise so every sequence starts on a full window.
module flasher_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/bound_flasher_gen.sv
// Bounded lamp flasher: ramps a lit-count N up and down between fixed bounds,
// with flick-triggered kickbacks at the bound points.
module bound_flasher_gen
    import bound_flasher_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int B_LO  = 5,
    parameter int B_HI  = 10,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic [2:0]       phase
);

    localparam int NW = $clog2(WIDTH + 1);
    localparam logic [NW-1:0] TOP_N = NW'(WIDTH);
    localparam logic [NW-1:0] LO_N  = NW'(B_LO);
    localparam logic [NW-1:0] HI_N  = NW'(B_HI);

    if (!params_ok(WIDTH, B_LO, B_HI, DIV)) begin : g_bad_params
        $error("bound_flasher_gen: illegal WIDTH/B_LO/B_HI/DIV combination");
    end

    state_t        state, state_nx;
    state_t        resume_q, resume_nx;
    state_t        dn_exit;
    logic [NW-1:0] n, n_nx, n_inc, n_dec;
    logic [NW-1:0] floor_q, floor_nx, dn_floor;
    logic          run, tick, kick, flick_req;

    assign run = (state != IDLE);

    flasher_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    // A flick anywhere in the tick window counts at the window's closing tick.
    assign kick  = tick & (flick | flick_req);
    assign n_inc = n + NW'(1);
    assign n_dec = n - NW'(1);

    always_comb begin
        dn_floor = '0;
        dn_exit  = IDLE;
        case (state)
            S2_DN: begin
                dn_floor = LO_N;
                dn_exit  = S3_UP;
            end
            S4_DN: dn_exit = S5_UP;
            S6_DN: dn_exit = IDLE;
            KB_DN: begin
                dn_floor = floor_q;
                dn_exit  = resume_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx  = state;
        n_nx      = n;
        floor_nx  = floor_q;
        resume_nx = resume_q;
        case (state)
            IDLE: begin
                if (flick) begin
                    state_nx = S1_UP;
                    n_nx     = '0;
                end
            end
            S1_UP: begin
                if (tick) begin
                    if (n == TOP_N) begin
                        state_nx = S2_DN;
                        n_nx     = n_dec;
                    end else if (kick && (n == LO_N || n == HI_N)) begin
                        state_nx  = KB_DN;
                        floor_nx  = '0;
                        resume_nx = S1_UP;
                        n_nx      = n_dec;
                    end else begin
                        n_nx = n_inc;
                    end
                end
            end
            S3_UP: begin
                if (tick) begin
                    if (n == HI_N) begin
                        state_nx = kick ? S2_DN : S4_DN;
                        n_nx     = n_dec;
                    end else begin
                        n_nx = n_inc;
                    end
                end
            end
            S5_UP: begin
                if (tick) begin
                    if (n == LO_N) begin
                        if (kick) begin
                            state_nx  = KB_DN;
                            floor_nx  = '0;
                            resume_nx = S5_UP;
                        end else begin
                            state_nx = S6_DN;
                        end
                        n_nx = n_dec;
                    end else begin
                        n_nx = n_inc;
                    end
                end
            end
            S2_DN, S4_DN, S6_DN, KB_DN: begin
                if (tick) begin
                    if (n == dn_floor) begin
                        state_nx = dn_exit;
                        n_nx     = (dn_exit == IDLE) ? n : n_inc;
                    end else begin
                        n_nx = n_dec;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                n_nx     = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they track state/N exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            n         <= '0;
            floor_q   <= '0;
            resume_q  <= S1_UP;
            flick_req <= 1'b0;
            led       <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            n         <= n_nx;
            floor_q   <= floor_nx;
            resume_q  <= resume_nx;
            flick_req <= tick ? 1'b0 : (flick_req | flick);
            led       <= ~({WIDTH{1'b1}} << n_nx);
            busy      <= (state_nx != IDLE);
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Scoreboard bench for bound_flasher_gen: expected (phase, lit-count) trajectories
// are queued as ramp segments and compared against the DUT every cycle.
module tb_bound_flasher_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flick = 1'b0;
    logic [15:0] led_a, led_b;
    logic [7:0]  led_c;
    logic        busy_a, busy_b, busy_c;
    logic [2:0]  phase_a, phase_b, phase_c;

    always #5 clk = ~clk;

    bound_flasher_gen #(.WIDTH(16), .B_LO(5), .B_HI(10), .DIV(1)) dut_a (
        .clk(clk), .rst(rst), .flick(flick), .led(led_a), .busy(busy_a), .phase(phase_a));
    bound_flasher_gen #(.WIDTH(16), .B_LO(5), .B_HI(10), .DIV(4)) dut_b (
        .clk(clk), .rst(rst), .flick(flick), .led(led_b), .busy(busy_b), .phase(phase_b));
    bound_flasher_gen #(.WIDTH(8), .B_LO(2), .B_HI(5), .DIV(2)) dut_c (
        .clk(clk), .rst(rst), .flick(flick), .led(led_c), .busy(busy_c), .phase(phase_c));

    typedef struct {
        int ph;
        int n;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   sel = 0;
    int   cur_div = 1;
    int   kick_at;

    logic [63:0] obs_led;
    logic        obs_busy;
    logic [2:0]  obs_phase;

    always_comb begin
        obs_led   = {48'd0, led_a};
        obs_busy  = busy_a;
        obs_phase = phase_a;
        case (sel)
            1: begin
                obs_led   = {48'd0, led_b};
                obs_busy  = busy_b;
                obs_phase = phase_b;
            end
            2: begin
                obs_led   = {56'd0, led_c};
                obs_busy  = busy_c;
                obs_phase = phase_c;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] therm(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    // Queue lit counts from..to inclusive in one phase, each held cur_div cycles.
    task automatic seg(input int ph, input int from, input int to);
        int step;
        step = (to >= from) ? 1 : -1;
        for (int v = from; v != to + step; v += step)
            for (int r = 0; r < cur_div; r++)
                q.push_back('{ph, v});
    endtask

    task automatic tail_from_s4(input int lo, input int hi);
        seg(4, hi - 1, 0);
        seg(5, 1, lo);
        seg(6, lo - 1, 0);
        seg(0, 0, 0);
        seg(0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst   = 1'b0;
        flick = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_led"}, obs_led, 64'd0);
        chk({tag, "_rst_phase"}, {61'd0, obs_phase}, 64'd0);
        chk({tag, "_rst_busy"}, {63'd0, obs_busy}, 64'd0);
        rst = 1'b1;
    endtask

    // One-cycle start flick, then flick high only in the cycle after sample 'kick'.
    task automatic run_case(input string tag, input int kick);
        exp_t e;
        int   k;
        k = 0;
        @(negedge clk);
        flick = 1'b1;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            chk({tag, "_led"}, obs_led, therm(e.n));
            chk({tag, "_phase"}, {61'd0, obs_phase}, 64'(e.ph));
            chk({tag, "_busy"}, {63'd0, obs_busy}, {63'd0, (e.ph != 0)});
            flick = (k == kick);
            k++;
        end
        flick = 1'b0;
    endtask

    initial begin
        // Plain run, no kicks.
        sel = 0; cur_div = 1;
        do_reset("a");
        seg(1, 0, 16); seg(2, 15, 5); seg(3, 6, 10); tail_from_s4(5, 10);
        run_case("plain", -1);

        // Kickback from S1_UP at the high bound.
        do_reset("b");
        seg(1, 0, 10);
        kick_at = q.size() - 1;
        seg(7, 9, 0); seg(1, 1, 16); seg(2, 15, 5); seg(3, 6, 10); tail_from_s4(5, 10);
        run_case("kb_s1", kick_at);

        // Kick at the top of S3_UP re-descends to the low bound.
        do_reset("c");
        seg(1, 0, 16); seg(2, 15, 5); seg(3, 6, 10);
        kick_at = q.size() - 1;
        seg(2, 9, 5); seg(3, 6, 10); tail_from_s4(5, 10);
        run_case("kb_s3", kick_at);

        // Reset mid-ramp, then a fresh start.
        do_reset("d");
        seg(1, 0, 8);
        run_case("pre_rst", -1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_led", obs_led, 64'd0);
        chk("midrst_phase", {61'd0, obs_phase}, 64'd0);
        chk("midrst_busy", {63'd0, obs_busy}, 64'd0);
        rst = 1'b1;
        seg(1, 0, 4);
        run_case("restart", -1);

        // DIV=4: a short pulse inside the window is latched for the next tick.
        sel = 1; cur_div = 4;
        do_reset("e");
        seg(1, 0, 5);
        kick_at = q.size() - cur_div + 1;
        seg(7, 4, 0); seg(1, 1, 16); seg(2, 15, 5); seg(3, 6, 10); tail_from_s4(5, 10);
        run_case("latch", kick_at);

        // Small geometry with DIV=2.
        sel = 2; cur_div = 2;
        do_reset("f");
        seg(1, 0, 8); seg(2, 7, 2); seg(3, 3, 5); tail_from_s4(2, 5);
        run_case("small", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
